// File: rtl/key_debouncer.sv
// key_debouncer: per-channel input conditioning for board push-buttons and
// slide switches. Each channel has a two-flop synchronizer, a stable-time
// debounce counter, registered press/release pulses and a hold-to-repeat FSM.
// All channels are identical and independent. Every output is registered.
module key_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 12000000,
  parameter int REPEAT_PERIOD   = 2400000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] raw_in_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] press_o,
  output logic [WIDTH-1:0] release_o,
  output logic [WIDTH-1:0] repeat_o
);

  localparam int DCNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W  = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  // REPEAT_DELAY == 0 disables repeat; the terminal value is then never used.
  localparam logic [RCNT_W-1:0] DELAY_LAST  = (REPEAT_DELAY > 0) ? RCNT_W'(REPEAT_DELAY - 1) : '0;
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);
  localparam bit                REPEAT_EN   = (REPEAT_DELAY > 0);

  // Raw value of an idle (not pressed / inactive) pin.
  localparam logic [WIDTH-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RPT  = 2'd2
  } rpt_state_e;

  logic [WIDTH-1:0]  sync1_q, sync2_q;
  logic [WIDTH-1:0]  sample;

  logic [WIDTH-1:0]  level_q,   level_d;
  logic [WIDTH-1:0]  press_q,   press_d;
  logic [WIDTH-1:0]  release_q, release_d;
  logic [WIDTH-1:0]  repeat_q,  repeat_d;
  logic [DCNT_W-1:0] dcnt_q [WIDTH];
  logic [DCNT_W-1:0] dcnt_d [WIDTH];
  logic [RCNT_W-1:0] rcnt_q [WIDTH];
  logic [RCNT_W-1:0] rcnt_d [WIDTH];
  rpt_state_e        state_q [WIDTH];
  rpt_state_e        state_d [WIDTH];

  // Two-flop synchronizer; reset parks it at the idle pin value so no
  // spurious edge is seen when reset is released.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= INACTIVE;
      sync2_q <= INACTIVE;
    end else begin
      sync1_q <= raw_in_i;
      sync2_q <= sync1_q;
    end
  end

  // Normalized sample: 1 means pressed/active regardless of pin polarity.
  assign sample = sync2_q ^ INACTIVE;

  // Debounce: count consecutive cycles where the sample disagrees with the
  // accepted level; any agreement restarts the window.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int c = 0; c < WIDTH; c++) begin
      dcnt_d[c] = '0;
      if (sample[c] != level_q[c]) begin
        if (dcnt_q[c] == DCNT_LAST) begin
          level_d[c]   = sample[c];
          press_d[c]   = sample[c];
          release_d[c] = ~sample[c];
        end else begin
          dcnt_d[c] = dcnt_q[c] + 1'b1;
        end
      end
    end
  end

  // Hold-to-repeat FSM next state; a release on the same edge as a terminal
  // count wins, so no repeat pulse accompanies a release.
  always_comb begin
    repeat_d = '0;
    for (int c = 0; c < WIDTH; c++) begin
      state_d[c] = state_q[c];
      rcnt_d[c]  = rcnt_q[c];
      case (state_q[c])
        IDLE: begin
          rcnt_d[c] = '0;
          if (REPEAT_EN && press_d[c]) begin
            state_d[c] = WAIT;
          end
        end
        WAIT: begin
          if (release_d[c]) begin
            state_d[c] = IDLE;
            rcnt_d[c]  = '0;
          end else if (rcnt_q[c] == DELAY_LAST) begin
            repeat_d[c] = 1'b1;
            rcnt_d[c]   = '0;
            state_d[c]  = RPT;
          end else begin
            rcnt_d[c] = rcnt_q[c] + 1'b1;
          end
        end
        RPT: begin
          if (release_d[c]) begin
            state_d[c] = IDLE;
            rcnt_d[c]  = '0;
          end else if (rcnt_q[c] == PERIOD_LAST) begin
            repeat_d[c] = 1'b1;
            rcnt_d[c]   = '0;
          end else begin
            rcnt_d[c] = rcnt_q[c] + 1'b1;
          end
        end
        default: begin
          state_d[c] = IDLE;
          rcnt_d[c]  = '0;
        end
      endcase
    end
  end

  // State and output registers; reset clears every counter, level and pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      for (int c = 0; c < WIDTH; c++) begin
        dcnt_q[c]  <= '0;
        rcnt_q[c]  <= '0;
        state_q[c] <= IDLE;
      end
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      for (int c = 0; c < WIDTH; c++) begin
        dcnt_q[c]  <= dcnt_d[c];
        rcnt_q[c]  <= rcnt_d[c];
        state_q[c] <= state_d[c];
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed phases followed by randomized bouncy
// stimulus, predicted by a behavioural model and checked via a scoreboard.
module tb_key_debouncer;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam logic [W-1:0] INACT = 4'hF;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] raw;
  logic [W-1:0] level, press, rel, rpt;

  always #5 clk = ~clk;

  key_debouncer #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_i(clk), .reset_i(rst), .raw_in_i(raw),
    .level_o(level), .press_o(press), .release_o(rel), .repeat_o(rpt)
  );

  typedef struct packed {
    logic [W-1:0] level;
    logic [W-1:0] press;
    logic [W-1:0] rel;
    logic [W-1:0] rpt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   running = 0;
  int   cyc = 0;

  // Reference model: the pin value reaches the debouncer two edges late; a
  // new level is accepted after D consecutive disagreeing samples; repeats
  // fall at RD, RD+RP, RD+2RP... edges after the press while still held.
  logic [W-1:0] pipe_q[$];
  logic [W-1:0] m_level;
  int           streak[W];
  int           held_since[W];
  int           edge_n = 0;

  function automatic exp_t model_edge(input logic r, input logic [W-1:0] raw_v);
    exp_t         e;
    logic [W-1:0] s;
    logic [W-1:0] prev;
    int           el;
    e = '0;
    edge_n++;
    if (r) begin
      pipe_q.delete();
      pipe_q.push_back(INACT);
      pipe_q.push_back(INACT);
      m_level = '0;
      for (int c = 0; c < W; c++) streak[c] = 0;
      return e;
    end
    s = pipe_q.pop_front() ^ INACT;
    pipe_q.push_back(raw_v);
    prev = m_level;
    for (int c = 0; c < W; c++) begin
      if (s[c] == m_level[c]) begin
        streak[c] = 0;
      end else begin
        streak[c]++;
        if (streak[c] >= D) begin
          m_level[c] = s[c];
          streak[c]  = 0;
          if (s[c]) begin
            e.press[c]    = 1'b1;
            held_since[c] = edge_n;
          end else begin
            e.rel[c] = 1'b1;
          end
        end
      end
      if (RD > 0 && prev[c] && !e.rel[c]) begin
        el = edge_n - held_since[c];
        if (el >= RD && ((el - RD) % RP) == 0) e.rpt[c] = 1'b1;
      end
    end
    e.level = m_level;
    return e;
  endfunction

  task automatic step(input logic r, input logic [W-1:0] v);
    @(negedge clk);
    rst = r;
    raw = v;
    exp_q.push_back(model_edge(r, v));
    running = 1'b1;
    @(posedge clk);
  endtask

  task automatic hold(input int n, input logic [W-1:0] v);
    for (int i = 0; i < n; i++) step(1'b0, v);
  endtask

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Monitor: one response per clock; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("level",   level, e.level);
        chk("press",   press, e.press);
        chk("release", rel,   e.rel);
        chk("repeat",  rpt,   e.rpt);
      end else if (running) begin
        total++;
        bad++;
        $display("FAIL no_prediction cyc=%0d got=0 want=1", cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cnt[W];
    int           bnc[W];
    logic         tgt[W];
    logic [W-1:0] v;
    rst = 1'b1;
    raw = INACT;

    // Reset and idle
    repeat (3) step(1'b1, 4'hF);
    hold(20, 4'hF);
    // Clean press and release on channel 0
    hold(12, 4'hE);
    hold(12, 4'hF);
    // Bouncing channel 1
    for (int i = 0; i < 8; i++) step(1'b0, (i % 2 == 0) ? 4'hD : 4'hF);
    hold(12, 4'hD);
    hold(12, 4'hF);
    // Short glitch on channel 2
    hold(3, 4'hB);
    hold(14, 4'hF);
    // Long hold with repeats on channel 3
    hold(36, 4'h7);
    hold(14, 4'hF);
    // Reset while channel 0 is held
    hold(10, 4'hE);
    step(1'b1, 4'hE);
    hold(14, 4'hE);
    hold(12, 4'hF);

    // Randomized bouncy presses, holds and occasional resets
    for (int c = 0; c < W; c++) begin
      cnt[c] = 0;
      bnc[c] = 0;
      tgt[c] = 1'b1;
    end
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < W; c++) begin
        if (cnt[c] == 0) begin
          tgt[c] = ~tgt[c];
          cnt[c] = $urandom_range(1, 40);
          bnc[c] = $urandom_range(0, 6);
        end
        cnt[c]--;
        if (bnc[c] > 0) begin
          v[c] = 1'($urandom_range(0, 1));
          bnc[c]--;
        end else begin
          v[c] = tgt[c];
        end
      end
      step(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0, v);
    end

    running = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Input-side counterpart to the seven-segment display path: conditions raw board push-buttons (KEY) and slide switches (SW) into clean, clock-synchronous levels and single-cycle event pulses for downstream logic.
- Per channel: 2-flop synchronizer, stable-time debounce counter, press/release edge pulses, and an optional hold-to-repeat state machine.
- Sits directly behind the top-level KEY/SW pins, clocked from CLOCK_24[0].

Parameters:
- WIDTH, 4, number of independent input channels.
- DEBOUNCE_CYCLES, 240000, consecutive stable cycles required to accept a new level (10 ms at 24 MHz); minimum 1.
- ACTIVE_LOW, 1, 1 means raw_in low = pressed (KEY style); 0 means raw_in high = active (SW style).
- REPEAT_DELAY, 12000000, cycles held before the first repeat pulse (0.5 s); 0 disables repeat entirely.
- REPEAT_PERIOD, 2400000, cycles between subsequent repeat pulses (0.1 s); minimum 1.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- raw_in, input, WIDTH, asynchronous raw pin inputs.
- level, output, WIDTH, debounced level per channel, 1 = pressed/active.
- press, output, WIDTH, one-cycle pulse when level goes 0->1.
- release, output, WIDTH, one-cycle pulse when level goes 1->0.
- repeat, output, WIDTH, one-cycle auto-repeat pulse while held.

Behaviour:
- All channels are identical and fully independent. Every output is registered.
- Reset, sampled on a rising clk edge with reset=1:
  - Synchronizer flops load the inactive raw value (1 if ACTIVE_LOW, else 0).
  - level, press, release and repeat = 0.
  - All counters = 0; repeat FSM = IDLE.
- Synchronizer: two flops, sync1 <= raw_in, sync2 <= sync1. Normalized sample s = sync2 XOR ACTIVE_LOW.
- Debounce counter dcnt, width clog2(DEBOUNCE_CYCLES+1):
  - s == level: dcnt <= 0.
  - s != level and dcnt < DEBOUNCE_CYCLES-1: dcnt <= dcnt+1.
  - s != level and dcnt == DEBOUNCE_CYCLES-1: level <= s, dcnt <= 0. In the same cycle, press <= s, release <= ~s.
- Latency: with raw_in settled before edge 1, level and the matching pulse change on edge DEBOUNCE_CYCLES+2.
- Glitch rejection: any return of s to level before the count completes zeroes dcnt, with no output change. Bounces therefore restart the window.
- press, release and repeat are high for exactly one cycle, then return to 0.
- Repeat FSM (per channel), counter rcnt sized for max(REPEAT_DELAY, REPEAT_PERIOD):
  - IDLE: on the cycle level goes 1 (press pulse), go to WAIT with rcnt <= 0. If REPEAT_DELAY == 0, stay IDLE permanently.
  - WAIT: while level==1, rcnt increments. When rcnt == REPEAT_DELAY-1, pulse repeat, rcnt <= 0, go to RPT.
  - RPT: while level==1, rcnt increments. When rcnt == REPEAT_PERIOD-1, pulse repeat and rcnt <= 0.
  - WAIT/RPT when level goes 0 (release pulse): go to IDLE, rcnt <= 0.
- Simultaneous events:
  - release has priority. A repeat terminal count coinciding with the release cycle produces no repeat pulse.
  - press and repeat never assert in the same cycle.
- Reset mid-count or mid-hold: all state clears on that edge. An input still held after reset release produces a fresh press after the full latency, with no release pulse.
- Multiple channels may pulse in the same cycle; there is no arbitration.

Test Plan (WIDTH=4, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset: hold reset 3 cycles with raw_in=4'hF, then release -> level=0, press=release=repeat=0 for 20 cycles.
- Clean press: drive raw_in[0]=0 before edge 1, keep stable -> level[0]=1 and press[0]=1 on edge 6 only; press[0]=0 on edge 7; other channels stay 0.
- Bounce: raw_in[1] toggles 0,1,0,1 every cycle for 8 cycles, then holds 0 -> no pulses during toggling; press[1] asserts on the 6th edge after the last toggle.
- Glitch: single 3-cycle low pulse on raw_in[2] -> level[2] stays 0, no press or release, ever.
- Hold-repeat: hold raw_in[3]=0 for 30 cycles after press -> repeat[3] pulses 10 cycles after press, then every 3 cycles. On release, release[3] pulses after 6 edges, with no repeat pulse in or after the release cycle.
- Reset mid-hold: assert reset while level[0]=1 and raw_in[0]=0 -> outputs clear, no release pulse; press[0] reasserts on edge 6 after reset deasserts.
